// File: rtl/pattern_seq_if.sv
// Bundles the control inputs and serial outputs of the pattern sequence generator.
// The master drives start/pattern/len/abort/repeat_mode; the slave returns the serial stream and status.
interface pattern_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [3:0]       len;
    logic             abort;
    logic             repeat_mode;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;

    // Handshake: start is sampled only while idle, and pattern/len are captured on that same edge.
    // Each cycle with out_valid=1 carries exactly one pattern bit, and no backpressure exists.
    // done pulses for one cycle after the final bit of a transmission that was not aborted.
    modport master (
        output start, pattern, len, abort, repeat_mode,
        input  out_bit, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, len, abort, repeat_mode,
        output out_bit, out_valid, busy, done
    );
endinterface

// File: rtl/pattern_sequence_generator.sv
// Serialises the low L bits of a captured pattern MSB-first, followed by a one-cycle done pulse.
// Optional macro SEQ_GEN_REPEAT_EN enables continuous cycling while repeat_mode is high at the last bit.
module pattern_sequence_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pattern_seq_if.slave     bus,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] WIDTH_L = 4'(WIDTH);

`ifdef SEQ_GEN_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       idx_q, idx_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    logic [3:0]       eff_len;
    logic             repeat_req;
    logic             emit;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] mask;

    assign eff_len    = ((bus.len == 4'd0) || (bus.len > WIDTH_L)) ? WIDTH_L : bus.len;
    assign repeat_req = REPEAT_EN & bus.repeat_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // idx_q is the position of the bit currently on out_bit; reaching 0 means the last bit is showing.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        emit        = 1'b0;
        src         = pat_q;
        mask        = '0;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    len_d   = eff_len;
                    idx_d   = eff_len - 4'd1;
                    src     = bus.pattern;
                    emit    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (idx_q == 4'd0) begin
                    if (repeat_req) begin
                        idx_d = len_q - 4'd1;
                        emit  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q - 4'd1;
                    emit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mask        = WIDTH'(1) << idx_d;
        out_valid_d = emit;
        out_bit_d   = emit & (|(src & mask));
    end

    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign state_o       = state_q;
endmodule

// File: tb/tb_pattern_sequence_generator.sv
// Scoreboard bench for pattern_sequence_generator: directed cases plus randomised bursts,
// expected tokens come from a bit-list model of the serialisation rules.
module tb_pattern_sequence_generator;
  localparam int W = 8;
  localparam logic [1:0] TOK_DONE = 2'b10;

`ifdef SEQ_GEN_REPEAT_EN
  localparam bit TB_REPEAT = 1'b1;
`else
  localparam bit TB_REPEAT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pattern_seq_if #(.WIDTH(W)) bus ();
  logic [1:0] state_dbg;

  pattern_sequence_generator #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(state_dbg)
  );

  // scoreboard
  logic [1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got output with empty expected queue at %0t", name, $time);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [1:0] tok;
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) unexpected("unexpected_bit");
      else begin
        tok = exp_q.pop_front();
        chk("out_bit", {31'd0, bus.out_bit}, {30'd0, tok});
      end
    end else begin
      chk("idle_bit_zero", {31'd0, bus.out_bit}, 32'd0);
    end
    if (bus.done === 1'b1) begin
      chk("done_without_valid", {31'd0, bus.out_valid}, 32'd0);
      if (exp_q.size() == 0) unexpected("unexpected_done");
      else begin
        tok = exp_q.pop_front();
        chk("done_token", {30'd0, TOK_DONE}, {30'd0, tok});
      end
    end
  end

  function automatic int eff_len(input logic [3:0] ln);
    return ((ln == 4'd0) || (int'(ln) > W)) ? W : int'(ln);
  endfunction

  // driver: one transmission, optional abort on bit number abort_at, passes requested via repeat_mode
  task automatic run_burst(input logic [W-1:0] pat, input logic [3:0] ln,
                           input int abort_at, input int passes);
    int L, np, total, ncyc, ab;
    logic stream[$];
    L = eff_len(ln);
    np = TB_REPEAT ? passes : 1;
    total = L * np;
    ab = (abort_at >= 1 && abort_at <= total) ? abort_at : 0;
    ncyc = (ab != 0) ? ab : total;
    stream.delete();
    for (int p = 0; p < np; p++)
      for (int i = L - 1; i >= 0; i--) stream.push_back(pat[i]);
    for (int k = 0; k < ncyc; k++) exp_q.push_back({1'b0, stream[k]});
    if (ab == 0) exp_q.push_back(TOK_DONE);

    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = pat;
    bus.len = ln;
    bus.abort = 1'b0;
    bus.repeat_mode = 1'($urandom_range(0, 1));
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_in_shift", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'($urandom_range(0, 1));
      bus.pattern = W'($urandom);
      bus.len = 4'($urandom_range(0, 15));
      bus.repeat_mode = (c % L == 0) ? ((c / L) < passes) : 1'($urandom_range(0, 1));
      bus.abort = (c == ab);
    end
    if (ab != 0) begin
      @(posedge clk);
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
    end else begin
      @(negedge clk);
      chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'($urandom_range(0, 1));
      bus.abort = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.repeat_mode = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_bit"}, {31'd0, bus.out_bit}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_state_idle"}, {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    int ab, ln;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.len = '0;
    bus.abort = 1'b0;
    bus.repeat_mode = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // start accepted on the very first edge after reset release
    run_burst(8'h06, 4'd3, 0, 1);
    run_burst(8'hA5, 4'd0, 0, 1);
    run_burst(8'hA5, 4'd12, 0, 1);
    for (int i = 0; i < 3; i++) run_burst(8'h03, 4'd2, 0, 1);
    run_burst(8'hF0, 4'd8, 2, 1);
    run_burst(8'h5A, 4'd8, 0, 1);
    run_burst(8'h06, 4'd3, 0, 3);
    run_burst(8'h81, 4'd4, 4, 1);
    run_burst(8'h96, 4'd7, 0, 2);

    // asynchronous reset in the middle of a burst
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 8'hC3;
    bus.len = 4'd0;
    bus.abort = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_burst(8'h3C, 4'd5, 0, 1);

    for (int i = 0; i < 40; i++) begin
      ln = $urandom_range(0, 15);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_burst(W'($urandom), 4'(ln), ab, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(4);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
